// File: rtl/out_requant_drain.sv
// Output drain stage: requantises accepted psum rows into a small row FIFO and
// streams each buffered row out as SYS_COL/LANES beats of LANES elements.
module out_requant_drain #(
  parameter  int SYS_COL    = 16,
  parameter  int DATA_WIDTH = 16,
  parameter  int LANES      = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int PSUM_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic [15:0]                   row_count,
  input  logic [4:0]                    shift,
  input  logic                          relu_en,
  input  logic                          in_valid,
  input  logic [PSUM_WIDTH*SYS_COL-1:0] in_psum,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH*LANES-1:0]   out_data,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic                          sat_flag
);

  localparam int BEATS     = SYS_COL / LANES;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int ROW_W     = SYS_COL * DATA_WIDTH;
  localparam int BEAT_BITS = LANES * DATA_WIDTH;

  localparam logic signed [PSUM_WIDTH:0] SAT_MAX =
    {{(PSUM_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PSUM_WIDTH:0] SAT_MIN =
    {{(PSUM_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                state, state_nxt;
  logic [15:0]           cfg_rows;
  logic [4:0]            cfg_shift;
  logic                  cfg_relu;
  logic [15:0]           rows_in, rows_out;
  logic [BEAT_W-1:0]     beat;
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic [ROW_W-1:0]      mem [FIFO_DEPTH];
  logic [ROW_W-1:0]      head_row, q_row;
  logic [DATA_WIDTH:0]   el_res;
  logic                  q_sat;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, beat_hs, beat_wrap, last_row, start_job;

  // Returns {saturated, value}; the extra headroom bit keeps the rounding add from wrapping.
  function automatic logic [DATA_WIDTH:0] requant(input logic [PSUM_WIDTH-1:0] p,
                                                  input logic [4:0] sh,
                                                  input logic relu);
    logic signed [PSUM_WIDTH:0] x;
    logic signed [PSUM_WIDTH:0] rnd;
    x   = signed'({p[PSUM_WIDTH-1], p});
    rnd = '0;
    if (sh != 5'd0) rnd = signed'((PSUM_WIDTH+1)'(1) << (sh - 5'd1));
    x = (x + rnd) >>> sh;
    if (relu && x[PSUM_WIDTH]) x = '0;
    if (x > SAT_MAX) return {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
    if (x < SAT_MIN) return {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
    return {1'b0, x[DATA_WIDTH-1:0]};
  endfunction

  // NOTE: every variable written in an always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    q_row  = '0;
    q_sat  = 1'b0;
    el_res = '0;
    for (int c = 0; c < SYS_COL; c++) begin
      el_res = requant(in_psum[c*PSUM_WIDTH +: PSUM_WIDTH], cfg_shift, cfg_relu);
      q_row[c*DATA_WIDTH +: DATA_WIDTH] = el_res[DATA_WIDTH-1:0];
      q_sat = q_sat | el_res[DATA_WIDTH];
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head_row   = mem[rd_ptr[PTR_W-1:0]];
  assign beat_wrap  = (beat == BEAT_W'(BEATS - 1));
  assign last_row   = (rows_out == cfg_rows - 16'd1);
  assign push       = in_valid && in_ready;
  assign beat_hs    = out_valid && out_ready;
  assign pop        = beat_hs && beat_wrap;
  assign start_job  = (state == IDLE) && start && (row_count != 16'd0);

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (row_count != 16'd0) ? RUN : FIN;
      RUN:     if (beat_hs && out_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: ;
      RUN: begin
        busy      = 1'b1;
        in_ready  = !fifo_full && (rows_in < cfg_rows);
        out_valid = !fifo_empty;
        out_last  = !fifo_empty && beat_wrap && last_row;
        if (!fifo_empty) out_data = head_row[int'(beat)*BEAT_BITS +: BEAT_BITS];
      end
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        out_valid = !fifo_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cfg_rows  <= '0;
      cfg_shift <= '0;
      cfg_relu  <= 1'b0;
      rows_in   <= '0;
      rows_out  <= '0;
      beat      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (start_job) begin
        cfg_rows  <= row_count;
        cfg_shift <= shift;
        cfg_relu  <= relu_en;
        rows_in   <= '0;
        rows_out  <= '0;
        beat      <= '0;
        sat_flag  <= 1'b0;
      end
      if (push) begin
        wr_ptr  <= wr_ptr + (PTR_W+1)'(1);
        rows_in <= rows_in + 16'd1;
        if (q_sat) sat_flag <= 1'b1;
      end
      if (beat_hs) beat <= beat_wrap ? '0 : beat + BEAT_W'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + (PTR_W+1)'(1);
        rows_out <= rows_out + 16'd1;
      end
    end
  end

  // NOTE: row storage is deliberately not reset; the pointers define what is valid and out_data is gated when empty.
  always_ff @(posedge clk) begin
    if (rstn && push) mem[wr_ptr[PTR_W-1:0]] <= q_row;
  end

endmodule

// File: tb/tb_out_requant_drain.sv
// Directed bench for out_requant_drain: one task per scenario, inline comparisons.
module tb_out_requant_drain;

  localparam int SYS_COL   = 16;
  localparam int DW        = 16;
  localparam int LANES     = 4;
  localparam int FD        = 4;
  localparam int PW        = 2 * DW;
  localparam int ROW_BITS  = SYS_COL * PW;
  localparam int BEAT_BITS = LANES * DW;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 start;
  logic [15:0]          row_count;
  logic [4:0]           shift;
  logic                 relu_en;
  logic                 in_valid;
  logic [ROW_BITS-1:0]  in_psum;
  logic                 in_ready;
  logic                 out_valid;
  logic [BEAT_BITS-1:0] out_data;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic                 done;
  logic                 sat_flag;

  int tests = 0;
  int fails = 0;

  logic [ROW_BITS-1:0]  in_rows[$];
  int                   in_idx;
  bit                   in_hs_pend;
  logic [BEAT_BITS-1:0] beats_q[$];
  bit                   lasts_q[$];
  int                   done_cnt, done_at, last_at, cyc_now;

  always #5 clk = ~clk;

  out_requant_drain #(
    .SYS_COL(SYS_COL), .DATA_WIDTH(DW), .LANES(LANES), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .row_count(row_count), .shift(shift),
    .relu_en(relu_en), .in_valid(in_valid), .in_psum(in_psum), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  function automatic logic [ROW_BITS-1:0] seq_row(input int base);
    logic [ROW_BITS-1:0] r;
    r = '0;
    for (int c = 0; c < SYS_COL; c++) r[c*PW +: PW] = 32'(base + c);
    return r;
  endfunction

  function automatic logic [BEAT_BITS-1:0] mk_beat(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic clear_records();
    in_rows.delete();
    in_idx     = 0;
    in_hs_pend = 1'b0;
    beats_q.delete();
    lasts_q.delete();
    done_cnt = 0;
    done_at  = -1;
    last_at  = -1;
  endtask

  task automatic begin_job(input int rows, input int sh, input bit relu);
    @(negedge clk);
    start     = 1'b1;
    row_count = 16'(rows);
    shift     = 5'(sh);
    relu_en   = relu;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One cycle: drive inputs at the falling edge, sample outputs 1ns later.
  task automatic step(input bit rdy);
    @(negedge clk);
    cyc_now++;
    if (in_hs_pend) in_idx++;
    in_valid = (in_idx < in_rows.size());
    in_psum  = '0;
    if (in_valid) in_psum = in_rows[in_idx];
    out_ready = rdy;
    #1;
    in_hs_pend = in_valid && in_ready;
    if (done) begin
      done_cnt++;
      done_at = cyc_now;
    end
    if (out_valid && out_ready) begin
      beats_q.push_back(out_data);
      lasts_q.push_back(out_last);
      if (out_last) last_at = cyc_now;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (done_at < 0 && n < budget) begin
      step(1'b1);
      n++;
    end
    if (done_at >= 0) step(1'b1);
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; row_count = '0; shift = '0; relu_en = 1'b0;
    in_valid = 1'b0; in_psum = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++; if ({in_ready, out_valid, out_last, busy, done, sat_flag} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b, expected 000000", {in_ready, out_valid, out_last, busy, done, sat_flag}); end
    tests++; if (out_data !== '0) begin
      fails++; $display("FAIL reset_data: got %h, expected 0", out_data); end
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    int ones;
    clear_records();
    in_rows.push_back(seq_row(0));
    in_rows.push_back(seq_row(16));
    begin_job(2, 0, 1'b0);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b, expected 1", busy); end
    drain(100);
    tests++; if (beats_q.size() != 8) begin fails++; $display("FAIL basic_count: got %0d, expected 8", beats_q.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (beats_q[i] !== mk_beat(4*i, 4*i+1, 4*i+2, 4*i+3)) begin
        fails++; $display("FAIL basic_beat%0d: got %h, expected %h", i, beats_q[i], mk_beat(4*i, 4*i+1, 4*i+2, 4*i+3)); end
    end
    ones = 0;
    foreach (lasts_q[i]) if (lasts_q[i]) ones++;
    tests++; if (ones != 1 || lasts_q[7] !== 1'b1) begin
      fails++; $display("FAIL basic_last: got %0d last flags, beat8 last=%b, expected 1 and 1", ones, lasts_q[7]); end
    tests++; if (done_cnt != 1 || done_at != last_at + 1) begin
      fails++; $display("FAIL basic_done: got count %0d at %0d, expected 1 at %0d", done_cnt, done_at, last_at + 1); end
    tests++; if (sat_flag !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_end: got sat=%b busy=%b, expected 0 0", sat_flag, busy); end
  endtask

  task automatic run_one_row(input logic [ROW_BITS-1:0] row, input int sh, input bit relu);
    clear_records();
    in_rows.push_back(row);
    begin_job(1, sh, relu);
    drain(40);
  endtask

  task automatic test_requant();
    logic [ROW_BITS-1:0] r;
    r = '0;
    r[0*PW +: PW] = 32'(24);  r[1*PW +: PW] = 32'(-24); r[2*PW +: PW] = 32'(8);
    r[3*PW +: PW] = 32'(7);   r[4*PW +: PW] = 32'(-8);  r[5*PW +: PW] = 32'(-9);
    run_one_row(r, 4, 1'b0);
    tests++; if (beats_q.size() != 4 || done_cnt != 1) begin
      fails++; $display("FAIL rq_shift_job: got %0d beats %0d done, expected 4 1", beats_q.size(), done_cnt); end
    tests++; if (beats_q[0] !== mk_beat(2, -1, 1, 0)) begin
      fails++; $display("FAIL rq_shift_b0: got %h, expected %h", beats_q[0], mk_beat(2, -1, 1, 0)); end
    tests++; if (beats_q[1] !== mk_beat(0, -1, 0, 0)) begin
      fails++; $display("FAIL rq_shift_b1: got %h, expected %h", beats_q[1], mk_beat(0, -1, 0, 0)); end
    tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL rq_shift_sat: got %b, expected 0", sat_flag); end

    r = '0;
    r[0*PW +: PW] = 32'(-24); r[1*PW +: PW] = 32'(24); r[2*PW +: PW] = 32'(-9);
    run_one_row(r, 4, 1'b1);
    tests++; if (beats_q[0] !== mk_beat(0, 2, 0, 0)) begin
      fails++; $display("FAIL rq_relu: got %h, expected %h", beats_q[0], mk_beat(0, 2, 0, 0)); end

    r = '0;
    r[0*PW +: PW] = 32'h0010_0000; r[1*PW +: PW] = 32'hFFF0_0000;
    r[2*PW +: PW] = 32'(32767);    r[3*PW +: PW] = 32'(-32768);
    run_one_row(r, 0, 1'b0);
    tests++; if (beats_q[0] !== mk_beat(32767, -32768, 32767, -32768)) begin
      fails++; $display("FAIL rq_sat_val: got %h, expected %h", beats_q[0], mk_beat(32767, -32768, 32767, -32768)); end
    tests++; if (sat_flag !== 1'b1) begin fails++; $display("FAIL rq_sat_flag: got %b, expected 1", sat_flag); end

    r = '0;
    r[0*PW +: PW] = 32'h7FFF_FFFF; r[1*PW +: PW] = 32'h8000_0000;
    r[2*PW +: PW] = 32'h4000_0000; r[3*PW +: PW] = 32'hC000_0000;
    run_one_row(r, 31, 1'b0);
    tests++; if (beats_q[0] !== mk_beat(1, -1, 1, 0)) begin
      fails++; $display("FAIL rq_shift31: got %h, expected %h", beats_q[0], mk_beat(1, -1, 1, 0)); end
    tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL rq_sat_clear: got %b, expected 0", sat_flag); end
  endtask

  task automatic test_backpressure();
    logic [BEAT_BITS-1:0] hold;
    bit have_hold, stable_bad;
    int ones;
    clear_records();
    for (int r = 0; r < 6; r++) in_rows.push_back(seq_row(r * 100));
    begin_job(6, 0, 1'b0);
    have_hold = 1'b0; stable_bad = 1'b0; hold = '0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0);
      if (out_valid) begin
        if (!have_hold) begin hold = out_data; have_hold = 1'b1; end
        else if (out_data !== hold) stable_bad = 1'b1;
      end
    end
    tests++; if (in_idx != 4 || in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_fill: got %0d rows in_ready=%b, expected 4 0", in_idx, in_ready); end
    tests++; if (stable_bad || out_data !== mk_beat(0, 1, 2, 3)) begin
      fails++; $display("FAIL bp_stable: got %h unstable=%b, expected %h 0", out_data, stable_bad, mk_beat(0, 1, 2, 3)); end
    for (int k = 0; k < 5; k++) begin
      step(1'b1);
      if (k == 3) begin
        tests++; if (in_ready !== 1'b0 || !in_valid) begin
          fails++; $display("FAIL full_pop_ready: got %b, expected 0", in_ready); end
      end
      if (k == 4) begin
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
          fails++; $display("FAIL full_after_pop: got in_ready=%b out_valid=%b, expected 1 1", in_ready, out_valid); end
      end
    end
    drain(300);
    tests++; if (beats_q.size() != 24) begin fails++; $display("FAIL bp_count: got %0d, expected 24", beats_q.size()); end
    for (int i = 0; i < 24; i++) begin
      tests++; if (beats_q[i] !== mk_beat((i/4)*100 + (i%4)*4, (i/4)*100 + (i%4)*4 + 1,
                                           (i/4)*100 + (i%4)*4 + 2, (i/4)*100 + (i%4)*4 + 3)) begin
        fails++; $display("FAIL bp_beat%0d: got %h", i, beats_q[i]); end
    end
    ones = 0;
    foreach (lasts_q[i]) if (lasts_q[i]) ones++;
    tests++; if (ones != 1 || lasts_q[23] !== 1'b1 || done_cnt != 1) begin
      fails++; $display("FAIL bp_end: got %0d lasts, last23=%b, done=%0d, expected 1 1 1", ones, lasts_q[23], done_cnt); end
  endtask

  task automatic test_zero_and_ignore();
    clear_records();
    begin_job(0, 0, 1'b0);
    #1;
    tests++; if ({busy, done, out_valid} !== 3'b110) begin
      fails++; $display("FAIL zero_fin: got %b, expected 110", {busy, done, out_valid}); end
    @(negedge clk); #1;
    tests++; if ({busy, done, out_valid} !== 3'b000) begin
      fails++; $display("FAIL zero_idle: got %b, expected 000", {busy, done, out_valid}); end

    clear_records();
    in_rows.push_back(seq_row(200));
    begin_job(1, 0, 1'b0);
    @(negedge clk);
    start = 1'b1; row_count = 16'd3; shift = 5'd2; relu_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(40);
    tests++; if (beats_q.size() != 4 || done_cnt != 1) begin
      fails++; $display("FAIL ign_job: got %0d beats %0d done, expected 4 1", beats_q.size(), done_cnt); end
    tests++; if (beats_q[0] !== mk_beat(200, 201, 202, 203) || beats_q[3] !== mk_beat(212, 213, 214, 215)) begin
      fails++; $display("FAIL ign_data: got %h %h, expected %h %h", beats_q[0], beats_q[3],
                        mk_beat(200, 201, 202, 203), mk_beat(212, 213, 214, 215)); end
  endtask

  task automatic test_midjob_reset();
    int n;
    clear_records();
    in_rows.push_back(seq_row(0));
    in_rows.push_back(seq_row(16));
    begin_job(2, 0, 1'b0);
    n = 0;
    while (beats_q.size() < 3 && n < 50) begin step(1'b1); n++; end
    tests++; if (beats_q.size() != 3) begin fails++; $display("FAIL mr_pre: got %0d beats, expected 3", beats_q.size()); end
    @(negedge clk);
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); #1;
    tests++; if ({in_ready, out_valid, out_last, busy, done, sat_flag} !== 6'b0 || out_data !== '0) begin
      fails++; $display("FAIL mr_outputs: got %b data %h, expected 000000 0",
                        {in_ready, out_valid, out_last, busy, done, sat_flag}, out_data); end
    rstn = 1'b1;
    clear_records();
    repeat (6) step(1'b1);
    tests++; if (done_cnt != 0 || beats_q.size() != 0) begin
      fails++; $display("FAIL mr_quiet: got %0d done %0d beats, expected 0 0", done_cnt, beats_q.size()); end
    run_one_row(seq_row(50), 0, 1'b0);
    tests++; if (beats_q.size() != 4 || beats_q[0] !== mk_beat(50, 51, 52, 53) || done_cnt != 1) begin
      fails++; $display("FAIL mr_restart: got %0d beats first %h done %0d, expected 4 %h 1",
                        beats_q.size(), beats_q[0], done_cnt, mk_beat(50, 51, 52, 53)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    cyc_now = 0;
    test_reset();
    test_basic();
    test_requant();
    test_backpressure();
    test_zero_and_ignore();
    test_midjob_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/out_requant_drain.md
OUT_REQUANT_DRAIN -- requirements
Module: out_requant_drain

Interface
REQ-001 Parameters SHALL be, one per line:
- SYS_COL, 16, number of psum columns per row (multiple of LANES)
- DATA_WIDTH, 16, output element width
- LANES, 4, output elements per beat
- FIFO_DEPTH, 4, row buffer depth (power of 2, ≥2)
- PSUM_WIDTH (localparam), 2*DATA_WIDTH, input element width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  begin a drain job
- row_count  in  16  rows in the job
- shift  in  5  right-shift amount (0..PSUM_WIDTH-1)
- relu_en  in  1  clamp negatives to 0
- in_valid  in  1  psum row present
- in_psum  in  PSUM_WIDTH x SYS_COL  signed psum row, col 0 first
- in_ready  out  1  row accepted when in_valid and in_ready both high
- out_valid  out  1  beat present
- out_data  out  DATA_WIDTH x LANES  signed requantised beat
- out_ready  in  1  sink accepts beat
- out_last  out  1  final beat of job
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- sat_flag  out  1  sticky: some element saturated during job

Function
REQ-003 Reset SHALL be synchronous on rstn, active-low; clock SHALL be clk.
REQ-004 FSM states SHALL be IDLE, RUN and FIN.
REQ-005 In IDLE, start with row_count>0 SHALL latch row_count, shift and relu_en, clear sat_flag and row counters, and enter RUN. In IDLE, start with row_count=0 SHALL go to FIN.
REQ-006 start SHALL be ignored outside IDLE. Latched config SHALL hold for the whole job.
REQ-007 in_ready SHALL be high iff state=RUN, the FIFO is not full and rows_in < row_count. It SHALL NOT depend on out_ready; there is no full-FIFO bypass.
REQ-008 Each accepted row SHALL be requantised per element as follows:
- if shift>0, add 2^(shift-1) (round half up), then arithmetic right shift by shift, at PSUM_WIDTH+1 bits with no wrap
- if relu_en, map negative to 0
- saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]
REQ-009 Requantised rows SHALL be written to the FIFO registered. A row accepted in cycle N SHALL be visible at out_valid no earlier than cycle N+1.
REQ-010 Any saturated element of any accepted row SHALL set sat_flag in the cycle after acceptance.
REQ-011 out_valid SHALL be high iff the FIFO is non-empty.
REQ-012 Beat b of the head row SHALL carry columns b*LANES .. b*LANES+LANES-1, with lane 0 = lowest column.
REQ-013 The beat index SHALL advance on out_valid && out_ready. Its wrap from SYS_COL/LANES-1 to 0 SHALL pop the head row.
REQ-014 out_data SHALL hold stable while out_valid && !out_ready.
REQ-015 A simultaneous push and pop SHALL both take effect, leaving occupancy unchanged. FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 out_last SHALL be high on the last beat of row row_count-1 only.
REQ-017 RUN SHALL go to FIN in the cycle after the out_last beat handshake.
REQ-018 FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-019 busy SHALL be high in RUN and FIN.
REQ-020 In IDLE, in_ready and out_valid SHALL be 0 and out_data SHALL be 0.

Reset
REQ-021 While rstn=0 at a clock edge:
- state goes to IDLE
- FIFO is emptied and pointers, beat index and row counters are zeroed
- in_ready, out_valid, out_last, busy, done and sat_flag go to 0
- out_data goes to 0
REQ-022 Reset asserted mid-job SHALL abort the job. Buffered rows SHALL be discarded and no done pulse SHALL be produced.

Verification
REQ-023 Bench SHALL cover the following scenarios:
- row_count=2, shift=0, relu_en=0, columns=0..15, out_ready=1 -> 8 beats, first beat {0,1,2,3}, out_last on beat 8, done one cycle later, sat_flag=0.
- shift=4, psum=24 -> 2; psum=-24 -> -1; relu_en=1 with -24 -> 0; psum=0x00100000 with shift=0 -> 32767 and sat_flag=1.
- row_count=6, out_ready=0 -> in_ready drops after 4 rows accepted; out_data stays stable. Then out_ready=1 -> all 24 beats in order, no loss.
- FIFO full with simultaneous pop and in_valid -> in_ready=0 that cycle; occupancy goes 4→3, then the push is accepted next cycle.
- start with row_count=0 -> busy one cycle, done pulse, no out_valid. start during RUN -> ignored.
- rstn=0 after 3 beats -> all outputs 0 next cycle, no done. A new start then runs cleanly from beat 0.
